// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: NOP filler, FSM states and
// the queue entry layout.
package fetch_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HALT} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
    logic        misaligned;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/fetch_if.sv
// Wishbone instruction bus, redirect and decode-side handshake of the fetch unit.
interface fetch_if;
  logic [31:0] iwbm_addr_o;
  logic        iwbm_cyc_o;
  logic        iwbm_stb_o;
  logic [31:0] iwbm_dat_i;
  logic        iwbm_ack_i;
  logic        iwbm_err_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        e_fetch_fault_o;
  logic        e_misaligned_o;

  modport master (
    output iwbm_addr_o, iwbm_cyc_o, iwbm_stb_o,
    input  iwbm_dat_i, iwbm_ack_i, iwbm_err_i,
    input  redirect_i, redirect_pc_i,
    output inst_valid_o, instruction_o, pc_o, e_fetch_fault_o, e_misaligned_o,
    input  inst_ready_i
  );

  modport slave (
    input  iwbm_addr_o, iwbm_cyc_o, iwbm_stb_o,
    output iwbm_dat_i, iwbm_ack_i, iwbm_err_i,
    output redirect_i, redirect_pc_i,
    input  inst_valid_o, instruction_o, pc_o, e_fetch_fault_o, e_misaligned_o,
    output inst_ready_i
  );
endinterface

// File: rtl/fetch_fifo.sv
// Two-entry in-order queue; head is always slot e0. Flush wins over pop and
// may be combined with a push, leaving only the pushed entry.
module fetch_fifo #(
  parameter int             W       = 66,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] e0, e1;
  logic         do_push, do_pop;
  logic [1:0]   slot;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign slot    = count - {1'b0, do_pop};
  assign head    = e0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e0    <= RST_VAL;
      e1    <= RST_VAL;
      count <= 2'd0;
    end else if (flush) begin
      count <= {1'b0, push};
      if (push) e0 <= din;
    end else begin
      // shift first, then the push lands in the slot freed/left by the pop
      if (do_pop) e0 <= e1;
      if (do_push) begin
        if (slot == 2'd0) e0 <= din;
        else              e1 <= din;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/fetch.sv
// Instruction fetch: single-outstanding Wishbone master feeding a 2-entry
// queue toward decode, with redirect, drain of stale cycles and halt on faults.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
  input logic      clk_i,
  input logic      rst_i,
  fetch_if.master  bus
);
  localparam entry_t RST_ENTRY = '{inst: NOP, pc: RESET_ADDR, fault: 1'b0, misaligned: 1'b0};

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic [31:0] addr_q, addr_d, tgt_q, tgt_d, start_pc;
  logic        push, pop, flush, start, done, valid;
  logic [1:0]  count, cnt_nxt;
  entry_t      push_data, head;

  fetch_fifo #(.W(ENTRY_W), .RST_VAL(RST_ENTRY)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (push_data),
    .head  (head),
    .count (count)
  );

  assign valid               = (count != 2'd0);
  assign done                = cyc_q && (bus.iwbm_ack_i || bus.iwbm_err_i);
  assign bus.iwbm_addr_o     = addr_q;
  assign bus.iwbm_cyc_o      = cyc_q;
  assign bus.iwbm_stb_o      = cyc_q;
  assign bus.inst_valid_o    = valid;
  assign bus.instruction_o   = head.inst;
  assign bus.pc_o            = head.pc;
  assign bus.e_fetch_fault_o = head.fault;
  assign bus.e_misaligned_o  = head.misaligned;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    addr_d    = addr_q;
    tgt_d     = tgt_q;
    push      = 1'b0;
    flush     = 1'b0;
    pop       = valid && bus.inst_ready_i;
    start     = 1'b0;
    start_pc  = bus.redirect_pc_i;
    cnt_nxt   = count;
    push_data = '{inst: NOP, pc: addr_q, fault: 1'b0, misaligned: 1'b0};

    if (bus.redirect_i) begin
      flush = 1'b1;
      pop   = 1'b0;
      // a live bus cycle must run to completion before the target is fetched
      if (cyc_q && !done) begin
        state_d = S_DRAIN;
        tgt_d   = bus.redirect_pc_i;
      end else begin
        start = 1'b1;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (cyc_q && bus.iwbm_err_i) begin
            push            = 1'b1;
            push_data.fault = 1'b1;
            state_d         = S_HALT;
            cyc_d           = 1'b0;
          end else if (!cyc_q || bus.iwbm_ack_i) begin
            if (cyc_q) begin
              push           = 1'b1;
              push_data.inst = bus.iwbm_dat_i;
              addr_d         = addr_q + 32'd4;
            end
            cnt_nxt = count + {1'b0, push} - {1'b0, pop};
            if (cnt_nxt < 2'd2) begin
              cyc_d = 1'b1;
            end else begin
              cyc_d   = 1'b0;
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_nxt = count - {1'b0, pop};
          if (cnt_nxt < 2'd2) begin
            state_d = S_REQ;
            cyc_d   = 1'b1;
          end
        end
        S_DRAIN: begin
          if (done) begin
            start    = 1'b1;
            start_pc = tgt_q;
          end
        end
        S_HALT: ;
        default: ;
      endcase
    end

    if (start) begin
      if (start_pc[1:0] != 2'b00) begin
        push      = 1'b1;
        push_data = '{inst: NOP, pc: start_pc, fault: 1'b0, misaligned: 1'b1};
        state_d   = S_HALT;
        cyc_d     = 1'b0;
      end else begin
        addr_d  = start_pc;
        state_d = S_REQ;
        cyc_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_REQ;
      cyc_q   <= 1'b0;
      addr_q  <= RESET_ADDR;
      tgt_q   <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
    end
  end
endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: stimulus loads the expected program-order stream,
// a negedge monitor pops and compares every accepted instruction.
module tb_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RA  = 32'h8000_0000;
  localparam int          LEN = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus();
  fetch #(.RESET_ADDR(RA)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  // stimulus-side controls
  logic        rdy = 1'b1, redir = 1'b0, rand_ready = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0, salt = '0;
  int unsigned wait_n = 0, wcnt;
  logic        hit;

  assign bus.inst_ready_i  = rdy;
  assign bus.redirect_i    = redir;
  assign bus.redirect_pc_i = redir_pc;

  // Wishbone slave with programmable wait states and one faulting address
  assign hit             = bus.iwbm_cyc_o && bus.iwbm_stb_o && (wcnt >= wait_n);
  assign bus.iwbm_ack_i  = hit && !(err_en && bus.iwbm_addr_o == err_addr);
  assign bus.iwbm_err_i  = hit && err_en && (bus.iwbm_addr_o == err_addr);
  assign bus.iwbm_dat_i  = bus.iwbm_addr_o ^ salt;
  always @(posedge clk) begin
    if (rst || !bus.iwbm_cyc_o || hit) wcnt <= 0;
    else                               wcnt <= wcnt + 1;
  end

  int checks = 0, errors = 0, delivered = 0;
  entry_t expq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic entry_t mk(input logic [31:0] i, input logic [31:0] p, input logic f, input logic m);
    entry_t x;
    x.inst = i; x.pc = p; x.fault = f; x.misaligned = m;
    return x;
  endfunction

  // program-order reference: sequential words from the target, ending at a faulting word
  task automatic load_stream(input logic [31:0] a);
    logic [31:0] p;
    expq.delete();
    if (a[1:0] != 2'b00) begin
      expq.push_back(mk(NOP, a, 1'b0, 1'b1));
      return;
    end
    for (int i = 0; i < LEN; i++) begin
      p = a + 32'(4 * i);
      if (err_en && p == err_addr) begin
        expq.push_back(mk(NOP, p, 1'b1, 1'b0));
        return;
      end
      expq.push_back(mk(p ^ salt, p, 1'b0, 1'b0));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) rdy = 1'($urandom_range(0, 1));
  endtask

  // monitor: protocol rules plus scoreboard on each accepted head
  logic        p_cyc = 1'b0, p_done = 1'b0, p_rst = 1'b1;
  logic [31:0] p_addr = '0;
  entry_t      e;
  always @(negedge clk) begin
    if (!rst) begin
      chk("stb_eq_cyc", 32'(bus.iwbm_stb_o), 32'(bus.iwbm_cyc_o));
      if (p_cyc && !p_done && !p_rst) begin
        chk("cyc_hold", 32'(bus.iwbm_cyc_o), 32'd1);
        chk("addr_hold", bus.iwbm_addr_o, p_addr);
      end
      if (bus.iwbm_cyc_o) chk("addr_aligned", 32'(bus.iwbm_addr_o[1:0]), 32'd0);
      if (bus.inst_valid_o && rdy && !redir) begin
        if (expq.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          delivered++;
          chk("sb_pc", bus.pc_o, e.pc);
          chk("sb_inst", bus.instruction_o, e.inst);
          chk("sb_flags", {30'd0, bus.e_fetch_fault_o, bus.e_misaligned_o}, {30'd0, e.fault, e.misaligned});
        end
      end
    end
    p_cyc  = bus.iwbm_cyc_o;
    p_addr = bus.iwbm_addr_o;
    p_done = bus.iwbm_ack_i || bus.iwbm_err_i;
    p_rst  = rst;
  end

  task automatic find_mid_cycle(output logic found);
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.iwbm_cyc_o && wcnt == 1) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_cycle_found", 32'(found), 32'd1);
  endtask

  initial begin
    logic        found, acked;
    logic [31:0] held;
    int          acks, d0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", 32'(bus.iwbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(bus.iwbm_stb_o), 32'd0);
    chk("rst_valid", 32'(bus.inst_valid_o), 32'd0);
    chk("rst_inst", bus.instruction_o, NOP);
    chk("rst_pc", bus.pc_o, RA);
    chk("rst_faults", {30'd0, bus.e_fetch_fault_o, bus.e_misaligned_o}, 32'd0);
    chk("rst_addr", bus.iwbm_addr_o, RA);
    load_stream(RA);
    @(posedge clk); #1 rst = 1'b0;

    // zero-wait streaming: one instruction per cycle, no gaps
    @(negedge clk);
    chk("c1_cyc", 32'(bus.iwbm_cyc_o), 32'd0);
    chk("c1_valid", 32'(bus.inst_valid_o), 32'd0);
    @(negedge clk);
    chk("c2_cyc", 32'(bus.iwbm_cyc_o), 32'd1);
    chk("c2_addr", bus.iwbm_addr_o, RA);
    @(negedge clk);
    chk("c3_valid", 32'(bus.inst_valid_o), 32'd1);
    chk("c3_pc", bus.pc_o, RA);
    chk("c3_addr", bus.iwbm_addr_o, RA + 32'd4);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("stream_valid", 32'(bus.inst_valid_o), 32'd1);
      chk("stream_pc", bus.pc_o, RA + 32'(4 * k));
    end

    // decode stall: queue fills to two entries, bus goes idle
    tick(); rdy = 1'b0;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.iwbm_ack_i) acks++;
      chk("stall_valid", 32'(bus.inst_valid_o), 32'd1);
      if (k >= 1) chk("stall_cyc", 32'(bus.iwbm_cyc_o), 32'd0);
      tick();
    end
    rdy = 1'b1;
    chk("stall_acks", 32'(acks), 32'd1);
    repeat (10) tick();

    // slow slave with redirect mid-cycle: hold, drop stale data, restart at target
    wait_n = 3;
    repeat (6) tick();
    find_mid_cycle(found);
    held = bus.iwbm_addr_o;
    tick(); redir = 1'b1; redir_pc = 32'h8000_0100; load_stream(32'h8000_0100);
    tick(); redir = 1'b0;
    acked = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("drain_addr", bus.iwbm_addr_o, held);
      chk("drain_valid", 32'(bus.inst_valid_o), 32'd0);
      if (bus.iwbm_ack_i) begin
        acked = 1'b1;
        break;
      end
    end
    chk("drain_acked", 32'(acked), 32'd1);
    @(negedge clk);
    chk("redir_cyc", 32'(bus.iwbm_cyc_o), 32'd1);
    chk("redir_addr", bus.iwbm_addr_o, 32'h8000_0100);
    d0 = delivered;
    repeat (20) tick();
    chk("redir_progress", 32'(delivered > d0), 32'd1);

    // reset pulse in the middle of a bus cycle
    find_mid_cycle(found);
    tick(); rst = 1'b1; load_stream(RA);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("rstp_cyc", 32'(bus.iwbm_cyc_o), 32'd0);
    chk("rstp_stb", 32'(bus.iwbm_stb_o), 32'd0);
    chk("rstp_valid", 32'(bus.inst_valid_o), 32'd0);
    @(negedge clk);
    chk("rstp_restart_cyc", 32'(bus.iwbm_cyc_o), 32'd1);
    chk("rstp_restart_addr", bus.iwbm_addr_o, RA);
    repeat (20) tick();

    // bus error on the third word, then halt
    wait_n = 0; err_en = 1'b1; err_addr = RA + 32'd8;
    tick(); rst = 1'b1; load_stream(RA);
    tick(); tick(); rst = 1'b0;
    repeat (12) tick();
    chk("err_all_delivered", 32'(expq.size()), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("halt_idle", 32'(bus.iwbm_cyc_o), 32'd0);
    end

    // misaligned redirect target
    tick(); redir = 1'b1; redir_pc = 32'h8000_0102; load_stream(32'h8000_0102);
    tick(); redir = 1'b0;
    @(negedge clk);
    chk("mis_valid", 32'(bus.inst_valid_o), 32'd1);
    chk("mis_pc", bus.pc_o, 32'h8000_0102);
    chk("mis_flag", 32'(bus.e_misaligned_o), 32'd1);
    chk("mis_fault", 32'(bus.e_fetch_fault_o), 32'd0);
    for (int k = 0; k < 8; k++) begin
      chk("mis_cyc", 32'(bus.iwbm_cyc_o), 32'd0);
      @(negedge clk);
    end

    // address wrap across 2^32
    err_en = 1'b0;
    tick(); redir = 1'b1; redir_pc = 32'hFFFF_FFF8; load_stream(32'hFFFF_FFF8);
    tick(); redir = 1'b0;
    d0 = delivered;
    repeat (10) tick();
    chk("wrap_progress", 32'(delivered - d0 >= 5), 32'd1);

    // randomized ready, wait states and redirects
    tick(); salt = $urandom; redir = 1'b1; redir_pc = RA + 32'h40; load_stream(RA + 32'h40);
    rand_ready = 1'b1;
    d0 = delivered;
    for (int c = 0; c < 500; c++) begin
      tick();
      if (c % 50 == 0) wait_n = $urandom_range(0, 2);
      if ($urandom_range(0, 11) == 0) begin
        logic [31:0] t;
        t = RA + (32'($urandom_range(0, 255)) << 2);
        if ($urandom_range(0, 9) == 0) t[1:0] = 2'b10;
        redir = 1'b1; redir_pc = t; load_stream(t);
      end else begin
        redir = 1'b0;
      end
    end
    rand_ready = 1'b0;
    tick(); redir = 1'b0; rdy = 1'b1;
    repeat (10) tick();
    chk("rand_progress", 32'(delivered - d0 > 50), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_ADDR SHALL default to 32'h8000_0000; it is the first fetch address after reset.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 iwbm_addr_o  output  32  Wishbone instruction-bus address, word aligned.
REQ-005 iwbm_cyc_o / iwbm_stb_o  output  1 each  Wishbone cycle and strobe, driven identically.
REQ-006 iwbm_dat_i  input  32  read data.
REQ-007 iwbm_ack_i / iwbm_err_i  input  1 each  cycle termination, normal or error.
REQ-008 redirect_i  input  1  one-cycle request to restart fetch at a new address.
REQ-009 redirect_pc_i  input  32  target address, sampled when redirect_i=1.
REQ-010 inst_valid_o  output  1  queue head is valid toward the decode stage.
REQ-011 inst_ready_i  input  1  decode accepts the head when inst_valid_o & inst_ready_i.
REQ-012 instruction_o / pc_o  output  32 each  head instruction word and its address.
REQ-013 e_fetch_fault_o / e_misaligned_o  output  1 each  head carries a bus error or a misaligned-target exception.

Function
REQ-014 States SHALL be REQ (bus cycle active), WAIT (queue full, bus idle), DRAIN (discard outstanding cycle after a redirect), HALT (stopped after an exception).
REQ-015 Classic single-outstanding Wishbone: once asserted, cyc/stb and addr SHALL hold until ack or err.
REQ-016 The block SHALL contain a 2-entry in-order queue of {instruction, pc, fault, misaligned}; output fields SHALL be the head entry.
REQ-017 cyc/stb SHALL be registered, and SHALL be asserted in REQ only when the next-cycle queue count is below 2; at count 2, the block SHALL go to WAIT and return to REQ once the count drops.
REQ-018 On ack in REQ, the block SHALL push {iwbm_dat_i, addr, 0, 0} and advance the fetch address by 4 (mod 2^32 wrap).
REQ-019 A zero-wait slave with inst_ready_i=1 SHALL sustain 1 instruction per cycle; push latency SHALL be 1 cycle from ack to inst_valid_o.
REQ-020 Simultaneous push and pop SHALL leave the count unchanged; pop with count 0 SHALL be impossible.
REQ-021 On err in REQ, the block SHALL push {32'h0000_0013, addr, 1, 0} and enter HALT, issuing no request until a redirect.
REQ-022 Redirect SHALL flush the queue (inst_valid_o=0 next cycle) and override any same-cycle pop or push.
REQ-023 Redirect with a bus cycle outstanding and no ack/err that cycle SHALL latch the target and enter DRAIN; the ack/err that ends the cycle SHALL be discarded, and REQ at the target SHALL follow in the next cycle.
REQ-024 Redirect without an outstanding cycle, or coincident with ack/err, SHALL start REQ at the target on the next cycle.
REQ-025 If redirect_pc_i[1:0]!=0, the block SHALL issue no bus cycle, push {32'h0000_0013, target, 0, 1} and enter HALT.
REQ-026 A redirect during DRAIN SHALL replace the latched target.

Reset
REQ-027 While rst_i=1: cyc/stb=0, inst_valid_o=0, both faults=0, instruction_o=32'h0000_0013, pc_o=RESET_ADDR, queue empty, addr=RESET_ADDR.
REQ-028 Reset SHALL override everything, including an outstanding bus cycle; the first request SHALL occur in the cycle after rst_i falls.

Structure
REQ-029 The shared package SHALL hold the NOP constant 32'h0000_0013 and the state encodings.
REQ-030 The queue SHALL be the sub-module fetch_fifo (2 entries, 66-bit payload, push/pop/flush, count output).

Verification
REQ-031 Reset, then a zero-wait slave returning data=addr and ready=1 -> addresses 0x8000_0000, _0004, _0008...; pc_o advances by 4 each cycle with no gaps.
REQ-032 ready=0 for 5 cycles -> exactly 2 entries captured, stb low for the rest; ready=1 -> in-order delivery, no loss or duplication.
REQ-033 3-wait slave, redirect to 0x8000_0100 mid-cycle -> addr held until ack, stale data dropped, next addr 0x8000_0100, first pc_o 0x8000_0100.
REQ-034 err on 0x8000_0008 -> head pc_o=0x8000_0008 with e_fetch_fault_o=1, then no cyc until a redirect.
REQ-035 Redirect to 0x8000_0102 -> e_misaligned_o=1, pc_o=0x8000_0102, cyc stays 0.
REQ-036 rst_i pulsed mid-cycle -> next cycle cyc/stb/inst_valid_o=0; fetch restarts at 0x8000_0000.
